// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM state
// type and the rotate/priority helpers used to pick a winner.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotate an 8-bit vector right by amt, so that bit i of the result is
  // vec[(i + amt) mod 8]; bit 0 of the result is the highest-priority slot.
  function automatic logic [ARB_N-1:0] rotr8(input logic [ARB_N-1:0]     vec,
                                             input logic [ARB_IDX_W-1:0] amt);
    logic [2*ARB_N-1:0] dbl;
    dbl = {vec, vec} >> amt;
    return dbl[ARB_N-1:0];
  endfunction

  // One-hot winner of vec, searching ptr, ptr+1, ..., wrapping past bit 7.
  // Returns all-zero when vec is empty.
  function automatic logic [ARB_N-1:0] pick_winner(input logic [ARB_N-1:0]     vec,
                                                   input logic [ARB_IDX_W-1:0] ptr);
    logic [ARB_N-1:0]     rot;
    logic [ARB_IDX_W-1:0] off;
    logic [ARB_IDX_W-1:0] idx;
    logic                 found;
    rot   = rotr8(vec, ptr);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < ARB_N; i++) begin
      if (!found && rot[i]) begin
        off   = ARB_IDX_W'(i);
        found = 1'b1;
      end
    end
    // 3-bit add wraps naturally, giving (ptr + off) mod 8.
    idx = ptr + off;
    return found ? (ARB_N'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/onehot_enc_8x3.sv
// Combinational one-hot to binary encoder; all-zero input encodes to 0.
module onehot_enc_8x3
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     onehot_i,
  output logic [ARB_IDX_W-1:0] idx_o
);

  // Each index bit is the OR of the one-hot positions that have it set.
  always_comb begin
    idx_o[0] = onehot_i[1] | onehot_i[3] | onehot_i[5] | onehot_i[7];
    idx_o[1] = onehot_i[2] | onehot_i[3] | onehot_i[6] | onehot_i[7];
    idx_o[2] = onehot_i[4] | onehot_i[5] | onehot_i[6] | onehot_i[7];
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// its encoded index and a valid flag. A grant is held while its requester
// keeps asking, but for at most MAX_HOLD cycles when someone else waits.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     grant,
  output logic [ARB_IDX_W-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t               state_q, state_d;
  logic [ARB_N-1:0]     grant_q, grant_d;
  logic [ARB_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [ARB_N-1:0]     others;
  logic [ARB_IDX_W-1:0] ptr_after_cur;
  logic                 hold_expired;

  // grant_q is one-hot on the current owner, so masking with it removes
  // exactly the bit at grant_idx_q.
  assign others        = req & ~grant_q;
  assign ptr_after_cur = grant_idx_q + ARB_IDX_W'(1);
  assign hold_expired  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state, next-grant and hold-counter logic for the IDLE/GRANT FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d = pick_winner(req, ptr_q);
          hold_d  = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (req[grant_idx_q]) begin
          if (!hold_expired) begin
            // Unlimited hold leaves the counter parked so it cannot wrap.
            if (MAX_HOLD != 0) hold_d = hold_q + HOLD_W'(1);
          end else if (others != '0) begin
            ptr_d   = ptr_after_cur;
            grant_d = pick_winner(others, ptr_after_cur);
            hold_d  = '0;
          end else begin
            // Nobody else is waiting: keep the owner and restart its window.
            hold_d = '0;
          end
        end else begin
          ptr_d  = ptr_after_cur;
          hold_d = '0;
          if (others != '0) begin
            // Hand over directly, without an idle bubble.
            grant_d = pick_winner(others, ptr_after_cur);
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_valid_d = |grant_d;

  onehot_enc_8x3 u_enc (
    .onehot_i (grant_d),
    .idx_o    (grant_idx_d)
  );

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule
